// File: rtl/aes_stream.sv
// AES-128 block stream engine (ECB or CTR) wrapped around an iterative AES-128 core.
//
// aes_core ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   trigger    one-cycle pulse: load key/plaintext and start an encryption
//   key        128-bit cipher key, must stay stable until done
//   plaintext  128-bit input block, must stay stable until done
//   ciphertext 128-bit result, valid while done is high
//   done       level; rises after the 10th round, cleared by the next trigger
//
// aes_stream ports:
//   clk, reset                 clock, asynchronous active-low reset
//   start, cfg_key, cfg_iv     begin a message; key/IV sampled when start is taken in IDLE
//   busy                       high from accepted start until the last block is emitted
//   in_data/valid/last/ready   input block stream
//   out_data/valid/last/ready  output block stream
//   ctr_wrap                   sticky: counter field wrapped during the current message

module aes_core (
    input  logic         clk,
    input  logic         reset,
    input  logic         trigger,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic [127:0] ciphertext,
    output logic         done
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
               {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic         running_q, running_d;
    logic         done_q, done_d;

    logic [31:0]  temp;
    logic [127:0] next_rk;
    logic [127:0] sr;
    logic [127:0] mc;

    always_comb begin
        // Key schedule: RotWord + SubWord of the last word, rcon into the top byte.
        temp = {sbox(rk_q[23:16]) ^ rcon_q, sbox(rk_q[15:8]), sbox(rk_q[7:0]), sbox(rk_q[31:24])};
        next_rk[127:96] = rk_q[127:96] ^ temp;
        next_rk[95:64]  = rk_q[95:64] ^ next_rk[127:96];
        next_rk[63:32]  = rk_q[63:32] ^ next_rk[95:64];
        next_rk[31:0]   = rk_q[31:0] ^ next_rk[63:32];

        // Byte n of the state is row n%4, column n/4; byte 0 is the MSB.
        sr = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr[127 - 8 * (r + 4 * c) -: 8] = sbox(state_q[127 - 8 * (r + 4 * ((c + r) % 4)) -: 8]);
            end
        end
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32 * c -: 32] = mix_col(sr[127 - 32 * c -: 32]);
        end

        state_d   = state_q;
        rk_d      = rk_q;
        round_d   = round_q;
        rcon_d    = rcon_q;
        running_d = running_q;
        done_d    = done_q;

        if (trigger) begin
            state_d   = plaintext ^ key;
            rk_d      = key;
            round_d   = 4'd1;
            rcon_d    = 8'h01;
            running_d = 1'b1;
            done_d    = 1'b0;
        end else if (running_q) begin
            rk_d    = next_rk;
            rcon_d  = xtime(rcon_q);
            state_d = ((round_q == 4'd10) ? sr : mc) ^ next_rk;
            if (round_q == 4'd10) begin
                running_d = 1'b0;
                done_d    = 1'b1;
            end else begin
                round_d = round_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= '0;
            rk_q      <= '0;
            round_q   <= '0;
            rcon_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rk_q      <= rk_d;
            round_q   <= round_d;
            rcon_q    <= rcon_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign ciphertext = state_q;
    assign done       = done_q;

endmodule

module aes_stream #(
    parameter int unsigned MODE_CTR  = 1,
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] cfg_key,
    input  logic [127:0] cfg_iv,
    output logic         busy,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [127:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         ctr_wrap
);

    localparam bit IsCtr = (MODE_CTR != 0);

    typedef enum logic [2:0] {StIdle, StAccept, StTrig, StWait, StEmit} state_e;

    state_e                 state_q, state_d;
    logic [127:0]           key_q, key_d;
    logic [127:0]           iv_q, iv_d;
    logic [127:0]           data_q, data_d;
    logic                   last_q, last_d;
    logic [CTR_WIDTH-1:0]   ctr_q, ctr_d;
    logic                   wrap_q, wrap_d;
    logic [127:0]           out_data_q, out_data_d;
    logic                   out_last_q, out_last_d;
    logic                   done_prev_q;

    logic                   core_rst;
    logic                   core_trigger;
    logic [127:0]           core_pt;
    logic [127:0]           core_ct;
    logic                   core_done;
    logic                   done_rise;

    assign core_rst     = ~reset;
    assign core_trigger = (state_q == StTrig);
    assign core_pt      = IsCtr ? {iv_q[127:CTR_WIDTH], ctr_q} : data_q;
    // A done level left high by the previous block must not complete the current one.
    assign done_rise    = core_done & ~done_prev_q;

    aes_core u_core (
        .clk        (clk),
        .reset      (core_rst),
        .trigger    (core_trigger),
        .key        (key_q),
        .plaintext  (core_pt),
        .ciphertext (core_ct),
        .done       (core_done)
    );

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        iv_d       = iv_q;
        data_d     = data_q;
        last_d     = last_q;
        ctr_d      = ctr_q;
        wrap_d     = wrap_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = cfg_key;
                    iv_d    = IsCtr ? cfg_iv : '0;
                    ctr_d   = IsCtr ? cfg_iv[CTR_WIDTH-1:0] : '0;
                    wrap_d  = 1'b0;
                    state_d = StAccept;
                end
            end
            StAccept: begin
                if (in_valid) begin
                    data_d  = in_data;
                    last_d  = in_last;
                    state_d = StTrig;
                end
            end
            StTrig: begin
                state_d = StWait;
            end
            StWait: begin
                if (done_rise) begin
                    out_data_d = IsCtr ? (core_ct ^ data_q) : core_ct;
                    out_last_d = last_q;
                    state_d    = StEmit;
                end
            end
            StEmit: begin
                if (out_ready) begin
                    if (IsCtr) begin
                        ctr_d = ctr_q + {{(CTR_WIDTH - 1){1'b0}}, 1'b1};
                        if (&ctr_q) wrap_d = 1'b1;
                    end
                    state_d = last_q ? StIdle : StAccept;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            key_q       <= '0;
            iv_q        <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            ctr_q       <= '0;
            wrap_q      <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            iv_q        <= iv_d;
            data_q      <= data_d;
            last_q      <= last_d;
            ctr_q       <= ctr_d;
            wrap_q      <= wrap_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_prev_q <= core_done;
        end
    end

    assign busy      = (state_q != StIdle);
    assign in_ready  = (state_q == StAccept);
    assign out_valid = (state_q == StEmit);
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign ctr_wrap  = wrap_q;

endmodule

// File: doc/aes_stream.md
AES_STREAM -- requirements
Module: aes_stream

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter MODE_CTR, default 1: 0 = ECB, 1 = CTR.
REQ-002 The block SHALL have parameter CTR_WIDTH, default 32, legal 8..64: counter field width, occupying bits [CTR_WIDTH-1:0] of the counter block.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1: begin a message; key and IV are sampled on this cycle.
REQ-006 The block SHALL have port cfg_key, input, 128: AES-128 key.
REQ-007 The block SHALL have port cfg_iv, input, 128: initial counter block (CTR); ignored in ECB.
REQ-008 The block SHALL have port busy, output, 1: high from accepted start until the last block is emitted.
REQ-009 The block SHALL have ports in_data, input, 128; in_valid, input, 1; in_last, input, 1; in_ready, output, 1: input block stream.
REQ-010 The block SHALL have ports out_data, output, 128; out_valid, output, 1; out_last, output, 1; out_ready, input, 1: output block stream.
REQ-011 The block SHALL have port ctr_wrap, output, 1: sticky; the counter field wrapped during the current message.

Function
REQ-012 The block SHALL instantiate the team's aes core (key, plaintext, ciphertext, trigger, done, clk, reset), driving the core's active-high reset with ~reset.
REQ-013 The FSM SHALL have states IDLE, ACCEPT, TRIG, WAIT, EMIT.
REQ-014 In IDLE, start=1 SHALL latch cfg_key and cfg_iv, set the counter to cfg_iv[CTR_WIDTH-1:0], clear ctr_wrap, and move to ACCEPT. In any other state, start SHALL be ignored.
REQ-015 ACCEPT: in_ready=1; on in_valid&in_ready, the block SHALL latch in_data and in_last and move to TRIG.
REQ-016 TRIG SHALL assert core trigger for exactly one cycle and then move to WAIT; core key and plaintext SHALL remain stable from TRIG until done is observed.
REQ-017 Core plaintext SHALL be in_data in ECB, and {iv[127:CTR_WIDTH], counter} in CTR.
REQ-018 WAIT SHALL move to EMIT on the first cycle core done is high after TRIG; a done level held high from a prior block SHALL NOT be accepted (rising-edge detect).
REQ-019 On WAIT->EMIT, out_data SHALL be registered as ciphertext (ECB) or ciphertext XOR latched in_data (CTR); out_last SHALL equal the latched in_last.
REQ-020 EMIT: out_valid=1. out_data and out_last SHALL hold stable until out_ready=1. On out_valid&out_ready, the block SHALL go to IDLE if out_last, else to ACCEPT.
REQ-021 In CTR, on each EMIT handshake the counter SHALL increment modulo 2^CTR_WIDTH; bits [127:CTR_WIDTH] SHALL never change. A transition from all-ones to zero SHALL set ctr_wrap, which SHALL hold until the next accepted start or reset. In ECB, the counter and ctr_wrap SHALL stay 0.
REQ-022 in_ready SHALL be 0 outside ACCEPT; out_valid SHALL be 0 outside EMIT; busy SHALL be 0 only in IDLE.
REQ-023 Neither in_ready nor out_valid SHALL depend combinationally on in_valid or out_ready.

Reset
REQ-024 reset=0 SHALL asynchronously force IDLE, busy=0, in_ready=0, out_valid=0, out_last=0, out_data=0, ctr_wrap=0, counter=0, and latched key/IV/data=0, including mid-message; the partial message SHALL be discarded.
REQ-025 After reset deassertion, the first start SHALL be honoured no earlier than the following clock edge.

Verification
REQ-026 ECB: key 000102030405060708090a0b0c0d0e0f, one block 00112233445566778899aabbccddeeff with in_last=1 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_last=1, busy low the cycle after the handshake.
REQ-027 CTR: same key, iv 00112233445566778899aabbccddeeff, in_data 0 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; a second block of 0 -> encryption of ...ccddef00 (counter +1).
REQ-028 CTR wrap: iv low 32 bits ffffffff, 2 blocks -> second counter block has low 32 bits 00000000 and upper 96 bits unchanged; ctr_wrap=1 after the first handshake and still 1 in IDLE.
REQ-029 Backpressure: out_ready held 0 for 10 cycles in EMIT -> out_data/out_last stable, in_ready=0, no counter change; releasing out_ready completes exactly one transfer.
REQ-030 Reset mid-WAIT of a 3-block message -> all outputs at reset values immediately; a subsequent start with a 1-block ECB message yields the correct single output.
REQ-031 start pulsed while busy -> ignored; key and counter unchanged; message completes normally.
